// File: rtl/subtractor_pipe_pkg.sv
// Shared helpers for the chunked, pipelined subtractor: default sizing and
// chunk geometry functions used when elaborating the stage chain.
package subtractor_pipe_pkg;

    localparam int unsigned DEF_WIDTH       = 62;
    localparam int unsigned DEF_CHUNK_WIDTH = 16;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    // Bit offset of chunk k inside the operand.
    function automatic int unsigned chunk_lo(input int unsigned k, input int unsigned cw);
        return k * cw;
    endfunction

    // Width of chunk k; only the top chunk may be narrower than cw.
    function automatic int unsigned chunk_w(input int unsigned k, input int unsigned width,
                                            input int unsigned cw);
        if (k == ceil_div(width, cw) - 1) begin
            return width - k * cw;
        end
        return cw;
    endfunction

endpackage : subtractor_pipe_pkg

// File: rtl/subtractor_pipe_sub_chunk_stage.sv
// One pipeline stage of the subtractor: resolves a single chunk of a-b from
// the incoming borrow and forwards the still-unconsumed operand bits.
module sub_chunk_stage
    import subtractor_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LO    = 0,
    parameter int unsigned CW    = DEF_CHUNK_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic             borrow_i,
    input  logic [WIDTH-1:0] res_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    output logic             borrow_o,
    output logic [WIDTH-1:0] res_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);

    localparam logic [WIDTH-1:0] ONES       = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CHUNK_MASK = (ONES >> (WIDTH - CW)) << LO;
    localparam logic [WIDTH-1:0] DONE_MASK  = ONES >> (WIDTH - LO - CW);

    logic [CW-1:0]    a_ch;
    logic [CW-1:0]    b_ch;
    logic [CW:0]      sum;

    logic             valid_d;
    logic             borrow_d;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;

    logic             valid_q;
    logic             borrow_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // a - b - bin as a + ~b + !bin; a clear carry-out means a borrow occurred.
    always_comb begin
        a_ch     = CW'(a_i >> LO);
        b_ch     = CW'(b_i >> LO);
        sum      = {1'b0, a_ch} + {1'b0, ~b_ch} + (CW+1)'(!borrow_i);
        valid_d  = valid_i;
        borrow_d = ~sum[CW];
        res_d    = (res_i & ~CHUNK_MASK) | (WIDTH'(sum[CW-1:0]) << LO);
        a_d      = a_i & ~DONE_MASK;
        b_d      = b_i & ~DONE_MASK;
    end

    // Whole pipeline shares one advance enable, so bubbles hold in place too.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            borrow_q <= 1'b0;
            res_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else if (adv_i) begin
            valid_q  <= valid_d;
            borrow_q <= borrow_d;
            res_q    <= res_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    assign valid_o  = valid_q;
    assign borrow_o = borrow_q;
    assign res_o    = res_q;
    assign a_o      = a_q;
    assign b_o      = b_q;

endmodule : sub_chunk_stage

// File: rtl/subtractor_pipe.sv
// Pipelined unsigned subtractor: diff = (a - b) mod 2^WIDTH with borrow-out,
// borrow chain split into CHUNK_WIDTH-bit stages under valid/ready control.
module subtractor_pipe
    import subtractor_pipe_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned CHUNK_WIDTH = DEF_CHUNK_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned NUM_CHUNKS = ceil_div(WIDTH, CHUNK_WIDTH);

    logic             adv;
    logic             stg_valid  [NUM_CHUNKS];
    logic             stg_borrow [NUM_CHUNKS];
    logic [WIDTH-1:0] stg_res    [NUM_CHUNKS];
    logic [WIDTH-1:0] stg_a      [NUM_CHUNKS];
    logic [WIDTH-1:0] stg_b      [NUM_CHUNKS];

    // The pipeline moves only when the output slot is empty or being drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_stage
        logic             v_in;
        logic             br_in;
        logic [WIDTH-1:0] res_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;

        if (k == 0) begin : g_head
            assign v_in   = in_valid;
            assign br_in  = 1'b0;
            assign res_in = '0;
            assign a_in   = a;
            assign b_in   = b;
        end else begin : g_body
            assign v_in   = stg_valid[k-1];
            assign br_in  = stg_borrow[k-1];
            assign res_in = stg_res[k-1];
            assign a_in   = stg_a[k-1];
            assign b_in   = stg_b[k-1];
        end

        sub_chunk_stage #(
            .WIDTH (WIDTH),
            .LO    (chunk_lo(k, CHUNK_WIDTH)),
            .CW    (chunk_w(k, WIDTH, CHUNK_WIDTH))
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .adv_i    (adv),
            .valid_i  (v_in),
            .borrow_i (br_in),
            .res_i    (res_in),
            .a_i      (a_in),
            .b_i      (b_in),
            .valid_o  (stg_valid[k]),
            .borrow_o (stg_borrow[k]),
            .res_o    (stg_res[k]),
            .a_o      (stg_a[k]),
            .b_o      (stg_b[k])
        );
    end

    // The last stage register is the output register.
    assign out_valid = stg_valid[NUM_CHUNKS-1];
    assign diff      = stg_res[NUM_CHUNKS-1];
    assign borrow    = stg_borrow[NUM_CHUNKS-1];

endmodule : subtractor_pipe

// File: tb/tb_subtractor_pipe.sv
// Scoreboard bench for subtractor_pipe: default 62/16 build plus an 8/8 and a
// 62/5 build, each checked against plain a-b arithmetic.
module tb_subtractor_pipe;

    localparam int unsigned W = 62;

    typedef struct {
        logic [W-1:0] diff;
        logic         brw;
        int unsigned  cyc;
        bit           chk_lat;
    } exp_t;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main build (62/16, 4 stages)
    logic         m_rst, m_iv, m_ir, m_ov, m_or, m_br;
    logic [W-1:0] m_a, m_b, m_d;
    bit           m_lat_en;
    exp_t         mq[$];

    // Sweep builds
    logic         s_rst;
    logic         s8_iv, s8_ir, s8_ov, s8_br;
    logic [7:0]   s8_a, s8_b, s8_d;
    exp_t         s8q[$];
    logic         s13_iv, s13_ir, s13_ov, s13_br;
    logic [W-1:0] s13_a, s13_b, s13_d;
    exp_t         s13q[$];
    logic         s_or;

    subtractor_pipe u_main (
        .clk(clk), .reset(m_rst), .in_valid(m_iv), .in_ready(m_ir), .a(m_a), .b(m_b),
        .out_valid(m_ov), .out_ready(m_or), .diff(m_d), .borrow(m_br)
    );

    subtractor_pipe #(.WIDTH(8), .CHUNK_WIDTH(8)) u_s8 (
        .clk(clk), .reset(s_rst), .in_valid(s8_iv), .in_ready(s8_ir), .a(s8_a), .b(s8_b),
        .out_valid(s8_ov), .out_ready(s_or), .diff(s8_d), .borrow(s8_br)
    );

    subtractor_pipe #(.WIDTH(62), .CHUNK_WIDTH(5)) u_s13 (
        .clk(clk), .reset(s_rst), .in_valid(s13_iv), .in_ready(s13_ir), .a(s13_a), .b(s13_b),
        .out_valid(s13_ov), .out_ready(s_or), .diff(s13_d), .borrow(s13_br)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic flag_fail(input string name);
        n_chk++;
        $display("FAIL %s: DUT presented a result with none expected (cycle %0d)", name, cyc);
    endtask

    // Reference model: plain modular subtraction and unsigned compare.
    function automatic exp_t model62(input logic [W-1:0] a, input logic [W-1:0] b, input bit lat);
        exp_t e;
        e.diff    = a - b;
        e.brw     = (a < b);
        e.cyc     = cyc;
        e.chk_lat = lat;
        return e;
    endfunction

    task automatic m_send(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned guard;
        bit          done;
        guard = 0;
        done  = 0;
        m_iv  = 1'b1;
        m_a   = a;
        m_b   = b;
        while (!done) begin
            @(negedge clk);
            if (m_ir && !m_rst) begin
                mq.push_back(model62(a, b, m_lat_en));
                done = 1;
            end else if (guard > 200) begin
                check("m_accept_timeout", 64'(m_ir), 64'd1);
                done = 1;
            end
            guard++;
            @(posedge clk);
            #1;
        end
        m_iv = 1'b0;
    endtask

    task automatic m_drain();
        int unsigned g;
        g = 0;
        while (mq.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("m_drain", 64'(mq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Main monitor: pops on every output transfer, also checks hold and in_ready.
    initial begin : m_mon
        exp_t         e;
        logic [W-1:0] pd;
        logic         pb;
        bit           held;
        held = 0;
        pd   = '0;
        pb   = 1'b0;
        forever begin
            @(negedge clk);
            if (!m_rst) begin
                check("m_in_ready", 64'(m_ir), 64'(!m_ov || m_or));
                if (held) begin
                    check("m_hold_valid", 64'(m_ov), 64'd1);
                    check("m_hold_diff", 64'(m_d), 64'(pd));
                    check("m_hold_borrow", 64'(m_br), 64'(pb));
                end
                if (m_ov && m_or) begin
                    if (mq.size() == 0) flag_fail("m_unexpected");
                    else begin
                        e = mq.pop_front();
                        check("m_diff", 64'(m_d), 64'(e.diff));
                        check("m_borrow", 64'(m_br), 64'(e.brw));
                        if (e.chk_lat) check("m_latency", 64'(cyc - e.cyc), 64'd4);
                    end
                end
                held = m_ov && !m_or;
                pd   = m_d;
                pb   = m_br;
            end else begin
                held = 0;
            end
        end
    end

    initial begin : s8_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (!s_rst && s8_ov) begin
                if (s8q.size() == 0) flag_fail("s8_unexpected");
                else begin
                    e = s8q.pop_front();
                    check("s8_diff", 64'(s8_d), 64'(e.diff));
                    check("s8_borrow", 64'(s8_br), 64'(e.brw));
                    check("s8_latency", 64'(cyc - e.cyc), 64'd1);
                end
            end
        end
    end

    initial begin : s13_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (!s_rst && s13_ov) begin
                if (s13q.size() == 0) flag_fail("s13_unexpected");
                else begin
                    e = s13q.pop_front();
                    check("s13_diff", 64'(s13_d), 64'(e.diff));
                    check("s13_borrow", 64'(s13_br), 64'(e.brw));
                    check("s13_latency", 64'(cyc - e.cyc), 64'd13);
                end
            end
        end
    end

    task automatic s8_run();
        exp_t       e;
        logic [7:0] d8;
        for (int i = 0; i < 65536; i++) begin
            s8_iv = 1'b1;
            s8_a  = 8'(i >> 8);
            s8_b  = 8'(i);
            @(negedge clk);
            if (s8_ir) begin
                d8        = s8_a - s8_b;
                e.diff    = W'(d8);
                e.brw     = (s8_a < s8_b);
                e.cyc     = cyc;
                e.chk_lat = 1;
                s8q.push_back(e);
            end else begin
                check("s8_in_ready", 64'(s8_ir), 64'd1);
            end
            @(posedge clk);
            #1;
        end
        s8_iv = 1'b0;
    endtask

    task automatic s13_run();
        for (int i = 0; i < 300; i++) begin
            s13_iv = 1'b1;
            if (i == 0) begin
                s13_a = W'(1);
                s13_b = W'(2);
            end else if (i == 1) begin
                s13_a = {W{1'b1}};
                s13_b = {W{1'b1}};
            end else begin
                s13_a = W'({$urandom(), $urandom()});
                s13_b = W'({$urandom(), $urandom()});
            end
            @(negedge clk);
            if (s13_ir) s13q.push_back(model62(s13_a, s13_b, 1));
            else check("s13_in_ready", 64'(s13_ir), 64'd1);
            @(posedge clk);
            #1;
        end
        s13_iv = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [W-1:0] ra, rb;
        m_rst = 1'b1;  s_rst = 1'b1;
        m_iv = 1'b0;   m_a = '0;  m_b = '0;  m_or = 1'b1;  m_lat_en = 1;
        s8_iv = 1'b0;  s8_a = '0; s8_b = '0;
        s13_iv = 1'b0; s13_a = '0; s13_b = '0;
        s_or = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_rst = 1'b0;
        s_rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(m_ov), 64'd0);
        check("rst_diff", 64'(m_d), 64'd0);
        check("rst_borrow", 64'(m_br), 64'd0);
        check("rst_in_ready", 64'(m_ir), 64'd1);
        @(posedge clk);
        #1;

        // Directed corner cases
        m_send(62'h10000, 62'h1);                               m_drain();
        m_send(62'h1, 62'h2);                                   m_drain();
        m_send(62'h3FFF_FFFF_FFFF_FFFF, 62'h0);                 m_drain();
        m_send(62'h2AAA_AAAA_AAAA_AAAA, 62'h2AAA_AAAA_AAAA_AAAA); m_drain();

        // Back-to-back random stream
        for (int i = 0; i < 8; i++) begin
            m_send(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}));
        end
        m_drain();

        // Backpressure: out_ready low for three cycles mid-stream
        m_lat_en = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    m_send(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}));
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                m_or = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(m_ir), 64'd0);
                end
                @(posedge clk);
                #1;
                m_or = 1'b1;
            end
        join
        m_drain();
        m_lat_en = 1;

        // Reset with three results in flight
        for (int i = 0; i < 3; i++) begin
            ra = W'({$urandom(), $urandom()}) | W'(64'h1_0000);
            rb = W'({$urandom(), $urandom()});
            m_send(ra, rb);
        end
        m_rst = 1'b1;
        @(negedge clk);
        mq.delete();
        @(posedge clk);
        #1;
        m_rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(m_ov), 64'd0);
        check("midrst_diff", 64'(m_d), 64'd0);
        check("midrst_borrow", 64'(m_br), 64'd0);
        @(posedge clk);
        #1;
        repeat (8) @(posedge clk);
        #1;
        m_send(62'h123_4567_89AB_CDEF, 62'h0FED_CBA9_8765_4321);
        m_drain();

        // Parameter sweep builds
        s8_run();
        s13_run();
        repeat (30) @(posedge clk);
        #1;
        check("m_queue_empty", 64'(mq.size()), 64'd0);
        check("s8_queue_empty", 64'(s8q.size()), 64'd0);
        check("s13_queue_empty", 64'(s13q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_subtractor_pipe
